// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: register index width,
// the zero register, FSM state encoding and the load-use detect helper.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_NORMAL  = 2'd0,
        SEL_FLUSH   = 2'd1,
        SEL_LOADUSE = 2'd2,
        SEL_FREEZE  = 2'd3
    } sel_e;

    // A load writing r0 never creates a dependency.
    function automatic logic load_use(
        input logic             memread,
        input logic [REG_W-1:0] load_rt,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return memread && (load_rt != REG_ZERO) &&
               ((load_rt == rs) || (uses_rt && (load_rt == rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (en_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, ID branch flushes, data-memory freeze,
// saturating event counters and a sticky freeze watchdog.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_FREEZE = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             dmem_stall_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o,
    output logic             timeout_o
);

    localparam int unsigned RLW = $clog2(MAX_FREEZE + 1);

    state_e         state_q;
    logic [RLW-1:0] run_len_q;
    logic [RLW-1:0] run_len_nx;
    sel_e           sel;
    logic           lu;

    // Case selection: freeze > load-use > branch flush > normal.
    always_comb begin
        lu  = load_use(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i);
        sel = SEL_NORMAL;
        if (dmem_stall_i)        sel = SEL_FREEZE;
        else if (lu)             sel = SEL_LOADUSE;
        else if (branch_taken_i) sel = SEL_FLUSH;
    end

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else begin
            case (sel)
                SEL_FREEZE: begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    freeze_o     = 1'b1;
                end
                SEL_LOADUSE: begin
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    idex_bubble_o = 1'b1;
                end
                SEL_FLUSH:  ifid_flush_o = 1'b1;
                default:    ;
            endcase
        end
    end

    // Consecutive frozen-cycle length, held at MAX_FREEZE once reached.
    always_comb begin
        run_len_nx = '0;
        if (dmem_stall_i) begin
            if (state_q == ST_RUN)                  run_len_nx = RLW'(1);
            else if (run_len_q != RLW'(MAX_FREEZE)) run_len_nx = run_len_q + RLW'(1);
            else                                    run_len_nx = run_len_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RUN;
            run_len_q <= '0;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= dmem_stall_i ? ST_FROZEN : ST_RUN;
            run_len_q <= run_len_nx;
            if (dmem_stall_i && (run_len_nx == RLW'(MAX_FREEZE))) begin
                timeout_o <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (sel == SEL_LOADUSE),
        .cnt_o (lu_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (sel == SEL_FLUSH),
        .cnt_o (flush_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (sel == SEL_FREEZE),
        .cnt_o (freeze_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table on a default instance, plus watchdog and
// saturation sequences on a small instance (CNT_W=2, MAX_FREEZE=4).
module tb_hazard_ctrl;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Default instance signals
    logic        rst_i, uses_rt, memread, br, stall;
    logic [4:0]  rs, rt, idex_rt;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, freeze, timeout;
    logic [15:0] lu_cnt, flush_cnt, freeze_cnt;

    // Small instance signals
    logic        s_rst, s_br, s_stall, s_zero1;
    logic [4:0]  s_zero5;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_freeze, s_timeout;
    logic [1:0]  s_lu_cnt, s_flush_cnt, s_freeze_cnt;

    int checks = 0;
    int failures = 0;

    hazard_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .ifid_rs_i(rs), .ifid_rt_i(rt),
        .ifid_uses_rt_i(uses_rt), .idex_memread_i(memread), .idex_rt_i(idex_rt),
        .branch_taken_i(br), .dmem_stall_i(stall),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .freeze_o(freeze), .lu_cnt_o(lu_cnt),
        .flush_cnt_o(flush_cnt), .freeze_cnt_o(freeze_cnt), .timeout_o(timeout)
    );

    hazard_ctrl #(.CNT_W(2), .MAX_FREEZE(4)) dut_s (
        .clk_i(clk_i), .rst_i(s_rst), .ifid_rs_i(s_zero5), .ifid_rt_i(s_zero5),
        .ifid_uses_rt_i(s_zero1), .idex_memread_i(s_zero1), .idex_rt_i(s_zero5),
        .branch_taken_i(s_br), .dmem_stall_i(s_stall),
        .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
        .idex_bubble_o(s_idex_bubble), .freeze_o(s_freeze), .lu_cnt_o(s_lu_cnt),
        .flush_cnt_o(s_flush_cnt), .freeze_cnt_o(s_freeze_cnt), .timeout_o(s_timeout)
    );

    typedef struct packed {
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic        memread;
        logic [4:0]  idex_rt;
        logic        br;
        logic        stall;
        logic [4:0]  ctrl;   // {pc_write, ifid_write, ifid_flush, idex_bubble, freeze}
        logic [15:0] lu;
        logic [15:0] fl;
        logic [15:0] fz;
        logic        to;
    } vec_t;

    localparam logic [4:0] C_RST = 5'b00110;
    localparam logic [4:0] C_NRM = 5'b11000;
    localparam logic [4:0] C_LU  = 5'b00010;
    localparam logic [4:0] C_FL  = 5'b11100;
    localparam logic [4:0] C_FZ  = 5'b00001;

    vec_t vecs[17];

    function automatic vec_t mk(
        input logic rst, input logic [4:0] rs_v, input logic [4:0] rt_v, input logic ur,
        input logic mr, input logic [4:0] irt, input logic b, input logic st,
        input logic [4:0] c, input int lu_v, input int fl_v, input int fz_v, input logic to_v
    );
        vec_t v;
        v.rst = rst; v.rs = rs_v; v.rt = rt_v; v.uses_rt = ur; v.memread = mr;
        v.idex_rt = irt; v.br = b; v.stall = st; v.ctrl = c;
        v.lu = 16'(lu_v); v.fl = 16'(fl_v); v.fz = 16'(fz_v); v.to = to_v;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic s_tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        s_rst = 1'b1; s_br = 1'b0; s_stall = 1'b0; s_zero1 = 1'b0; s_zero5 = 5'd0;
        rst_i = 1'b1; rs = 0; rt = 0; uses_rt = 0; memread = 0; idex_rt = 0; br = 0; stall = 0;

        //               rst rs  rt  ur mr irt br st ctrl   lu fl fz to
        vecs[0]  = mk(1, 0,  0,  0, 0, 0,  0, 0, C_RST, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0,  0,  0, 0, 0,  0, 0, C_RST, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0,  0,  0, 0, 0,  0, 0, C_NRM, 0, 0, 0, 0);
        vecs[3]  = mk(0, 8,  0,  0, 1, 8,  0, 0, C_LU,  1, 0, 0, 0);
        vecs[4]  = mk(0, 8,  0,  0, 0, 8,  0, 0, C_NRM, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0,  9,  1, 1, 9,  1, 0, C_LU,  2, 0, 0, 0);
        vecs[6]  = mk(0, 0,  9,  1, 0, 9,  1, 0, C_FL,  2, 1, 0, 0);
        vecs[7]  = mk(0, 0,  0,  0, 1, 0,  0, 0, C_NRM, 2, 1, 0, 0);
        vecs[8]  = mk(0, 3,  9,  0, 1, 9,  0, 0, C_NRM, 2, 1, 0, 0);
        vecs[9]  = mk(0, 0,  0,  0, 0, 0,  1, 1, C_FZ,  2, 1, 1, 0);
        vecs[10] = mk(0, 0,  0,  0, 0, 0,  1, 1, C_FZ,  2, 1, 2, 0);
        vecs[11] = mk(0, 0,  0,  0, 0, 0,  1, 1, C_FZ,  2, 1, 3, 0);
        vecs[12] = mk(0, 0,  0,  0, 0, 0,  1, 0, C_FL,  2, 2, 3, 0);
        vecs[13] = mk(0, 5,  0,  0, 1, 5,  0, 1, C_FZ,  2, 2, 4, 0);
        vecs[14] = mk(0, 5,  0,  0, 1, 5,  0, 0, C_LU,  3, 2, 4, 0);
        vecs[15] = mk(1, 5,  0,  0, 1, 5,  1, 1, C_RST, 0, 0, 0, 0);
        vecs[16] = mk(0, 0,  0,  0, 0, 0,  0, 0, C_NRM, 0, 0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk_i);
            rst_i = vecs[i].rst; rs = vecs[i].rs; rt = vecs[i].rt; uses_rt = vecs[i].uses_rt;
            memread = vecs[i].memread; idex_rt = vecs[i].idex_rt; br = vecs[i].br;
            stall = vecs[i].stall;
            #1;
            chk($sformatf("v%0d ctrl", i),
                int'({pc_write, ifid_write, ifid_flush, idex_bubble, freeze}), int'(vecs[i].ctrl));
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d lu_cnt", i), int'(lu_cnt), int'(vecs[i].lu));
            chk($sformatf("v%0d flush_cnt", i), int'(flush_cnt), int'(vecs[i].fl));
            chk($sformatf("v%0d freeze_cnt", i), int'(freeze_cnt), int'(vecs[i].fz));
            chk($sformatf("v%0d timeout", i), int'(timeout), int'(vecs[i].to));
        end

        // Watchdog at MAX_FREEZE=4 and freeze counter saturation at CNT_W=2
        @(negedge clk_i);
        s_rst = 1'b0; s_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            s_tick();
            chk($sformatf("s stall%0d timeout", k), int'(s_timeout), (k == 4) ? 1 : 0);
            chk($sformatf("s stall%0d freeze_cnt", k), int'(s_freeze_cnt), (k > 3) ? 3 : k);
        end
        @(negedge clk_i);
        s_stall = 1'b0;
        s_tick();
        chk("s timeout sticky", int'(s_timeout), 1);

        // Flush counter saturation
        @(negedge clk_i);
        s_br = 1'b1;
        #1;
        chk("s flush ctrl", int'(s_ifid_flush), 1);
        for (int k = 1; k <= 5; k++) begin
            s_tick();
            chk($sformatf("s flush%0d flush_cnt", k), int'(s_flush_cnt), (k > 3) ? 3 : k);
        end

        // Reset in the middle of a freeze leaves no run-length residue
        @(negedge clk_i);
        s_br = 1'b0; s_stall = 1'b1;
        s_tick();
        s_tick();
        chk("s timeout still sticky", int'(s_timeout), 1);
        @(negedge clk_i);
        s_rst = 1'b1;
        #1;
        chk("s reset ctrl", int'({s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_freeze}),
            int'(C_RST));
        s_tick();
        chk("s reset timeout", int'(s_timeout), 0);
        chk("s reset freeze_cnt", int'(s_freeze_cnt), 0);
        chk("s reset flush_cnt", int'(s_flush_cnt), 0);
        @(negedge clk_i);
        s_rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            s_tick();
            chk($sformatf("s post-reset stall%0d timeout", k), int'(s_timeout), (k == 4) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
